uart_rx_fifo: RTL

Oversampling UART receive path with a byte FIFO. It samples the serial RX line against a 16× baud TICK, frames 8N1 characters (8E1 when parity is compiled in), and flags framing and overrun errors. Received bytes are buffered in a first-word-fall-through FIFO. It sits between the pad-level RX pin and the processor-side consumer, and shares the TICK source (BaudSync, OVERSAMPLE=16) with the transmit path.

---
 rtl/uart_rx_fifo.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampled UART receiver feeding a first-word-fall-through byte FIFO; define UART_RX_PARITY_EN for 8E1 framing with parity checking
module uart_rx_fifo #(
  parameter int FIFO_AW = 2
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       RX,
  input  logic       TICK,
  input  logic       RD,
  input  logic       CLR_ERR,
  output logic [7:0] DOUT,
  output logic       EMPTY,
  output logic       FULL,
  output logic       FRAME_ERR,
  output logic       OVERRUN,
  output logic       PARITY_ERR
);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] LAST = (FIFO_AW + 1)'(DEPTH - 1);
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state_q;
  logic             meta_q, rxs_q;
  logic [3:0]       s_q;
  logic [2:0]       n_q;
  logic [7:0]       b_q;
  logic [7:0]       mem_q [DEPTH];
  logic [7:0]       mem_d [DEPTH];
  logic [FIFO_AW:0] wr_q, wr_d, rd_q, rd_d, cnt_q, cnt_d;
  logic             fe_q, fe_d, ov_q, ov_d;
  logic             stop_samp, good, push, pop, pbad;

  function automatic logic [FIFO_AW:0] inc(input logic [FIFO_AW:0] p);
    return p == LAST ? '0 : p + 1'b1;
  endfunction

  // two-flop synchronizer; idles high so reset does not look like a start bit
  always_ff @(posedge CLOCK or posedge RESET)
    if (RESET) {rxs_q, meta_q} <= 2'b11;
    else {rxs_q, meta_q} <= {meta_q, RX};

`ifdef UART_RX_PARITY_EN
  logic pbad_q, pe_q, pe_d;
  assign pbad = pbad_q;
  assign pe_d = (stop_samp & rxs_q & pbad_q) | (pe_q & ~CLR_ERR);
  // sticky parity error; a new event beats a simultaneous clear
  always_ff @(posedge CLOCK or posedge RESET)
    if (RESET) pe_q <= 1'b0;
    else pe_q <= pe_d;
  assign PARITY_ERR = pe_q;
`else
  assign pbad = 1'b0;
  assign PARITY_ERR = 1'b0;
`endif

  // frame FSM: confirm start at mid-bit, then sample every 16 ticks near bit centres
  always_ff @(posedge CLOCK or posedge RESET)
    if (RESET) begin
      state_q <= IDLE;
      s_q <= '0;
      n_q <= '0;
      b_q <= '0;
`ifdef UART_RX_PARITY_EN
      pbad_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE:
          if (!rxs_q) begin
            state_q <= START;
            s_q <= '0;
          end
        START:
          if (TICK) begin
            if (s_q == 4'd7) begin
              state_q <= rxs_q ? IDLE : DATA;
              s_q <= '0;
              n_q <= '0;
            end else s_q <= s_q + 4'd1;
          end
        DATA:
          if (TICK) begin
            if (s_q == 4'd15) begin
              s_q <= '0;
              b_q <= {rxs_q, b_q[7:1]};
              n_q <= n_q + 3'd1;
`ifdef UART_RX_PARITY_EN
              if (n_q == 3'd7) state_q <= PARITY;
`else
              if (n_q == 3'd7) state_q <= STOP;
`endif
            end else s_q <= s_q + 4'd1;
          end
`ifdef UART_RX_PARITY_EN
        PARITY:
          if (TICK) begin
            if (s_q == 4'd15) begin
              pbad_q <= rxs_q != ^b_q;
              state_q <= STOP;
              s_q <= '0;
            end else s_q <= s_q + 4'd1;
          end
`endif
        STOP:
          if (TICK) begin
            if (s_q == 4'd15) begin
              state_q <= IDLE;
              s_q <= '0;
            end else s_q <= s_q + 4'd1;
          end
        default: state_q <= IDLE;
      endcase
    end

  assign stop_samp = state_q == STOP && TICK && s_q == 4'd15;
  assign good = stop_samp & rxs_q & ~pbad;
  assign pop = RD & ~EMPTY;
  assign push = good & (~FULL | RD);
  assign fe_d = (stop_samp & ~rxs_q) | (fe_q & ~CLR_ERR);
  assign ov_d = (good & FULL & ~RD) | (ov_q & ~CLR_ERR);

  // FIFO next state; a simultaneous push and pop leaves the count unchanged
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q[FIFO_AW-1:0]] = b_q;
    wr_d = push ? inc(wr_q) : wr_q;
    rd_d = pop ? inc(rd_q) : rd_q;
    cnt_d = cnt_q + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);
  end

  // FIFO storage, pointers and sticky frame/overrun flags
  always_ff @(posedge CLOCK or posedge RESET)
    if (RESET) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      fe_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      fe_q <= fe_d;
      ov_q <= ov_d;
    end

  assign DOUT = mem_q[rd_q[FIFO_AW-1:0]];
  assign EMPTY = cnt_q == '0;
  assign FULL = cnt_q == FULL_CNT;
  assign FRAME_ERR = fe_q;
  assign OVERRUN = ov_q;
endmodule
